// File: rtl/recirc_merge.sv
// Merges recirculated 4-lane words with fresh words, buffering fresh traffic in a small FIFO.
// Optional sticky overflow flag: define RECIRC_MERGE_OVF_EN to add the overflow_err port.
module recirc_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic [DATA_WIDTH-1:0] data_3,
  input  logic                  valid_0,
  input  logic                  valid_1,
  input  logic                  valid_2,
  input  logic                  valid_3,
  input  logic [DATA_WIDTH-1:0] data_0r,
  input  logic [DATA_WIDTH-1:0] data_1r,
  input  logic [DATA_WIDTH-1:0] data_2r,
  input  logic [DATA_WIDTH-1:0] data_3r,
  input  logic                  valid_0r,
  input  logic                  valid_1r,
  input  logic                  valid_2r,
  input  logic                  valid_3r,
  output logic [DATA_WIDTH-1:0] data_0_out,
  output logic [DATA_WIDTH-1:0] data_1_out,
  output logic [DATA_WIDTH-1:0] data_2_out,
  output logic [DATA_WIDTH-1:0] data_3_out,
  output logic                  valid_0_out,
  output logic                  valid_1_out,
  output logic                  valid_2_out,
  output logic                  valid_3_out,
  output logic                  pause,
  output logic                  fifo_empty,
  output logic                  fifo_full,
`ifdef RECIRC_MERGE_OVF_EN
  output logic                  overflow_err,
`endif
  output logic [1:0]            state
);

  localparam int WW = 4*DATA_WIDTH + 4;
  localparam logic [1:0] ST_PASS   = 2'd0;
  localparam logic [1:0] ST_RECIRC = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(FIFO_DEPTH - 1);

  logic [WW-1:0]     fresh_w, recirc_w, head_w;
  logic [WW-1:0]     out_q, out_d;
  logic [WW-1:0]     mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic              pause_q, pause_d;
  logic              ovf_q;
  logic              fresh_present, recirc_present, empty_s, full_s;
  logic              push_req, pop, wr_en, drop;

  // Word layout: valids in the top nibble, lane 0 data in the low byte.
  assign fresh_w  = {valid_3, valid_2, valid_1, valid_0, data_3, data_2, data_1, data_0};
  assign recirc_w = {valid_3r, valid_2r, valid_1r, valid_0r, data_3r, data_2r, data_1r, data_0r};
  assign head_w   = mem_q[rd_ptr_q];
  assign fresh_present  = valid_0 | valid_1 | valid_2 | valid_3;
  assign recirc_present = valid_0r | valid_1r | valid_2r | valid_3r;
  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == DEPTH_C);

  always_comb begin
    out_d    = '0;
    state_d  = ST_PASS;
    push_req = 1'b0;
    pop      = 1'b0;
    if (recirc_present) begin
      out_d    = recirc_w;
      state_d  = ST_RECIRC;
      push_req = fresh_present;
    end else if (!empty_s) begin
      out_d    = head_w;
      state_d  = ST_DRAIN;
      pop      = 1'b1;
      push_req = fresh_present;
    end else if (fresh_present) begin
      out_d    = fresh_w;
      state_d  = ST_PASS;
    end else begin
      out_d    = '0;
      state_d  = ST_PASS;
    end
    // When full, a simultaneous pop frees the head slot that wr_ptr points at.
    wr_en = push_req && (!full_s || pop);
    drop  = push_req && full_s && !pop;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    pause_d = (count_d >= THRESH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      state_q  <= ST_PASS;
      pause_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      out_q   <= out_d;
      state_q <= state_d;
      pause_q <= pause_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (drop)  ovf_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= fresh_w;
  end

  assign data_0_out  = out_q[0*DATA_WIDTH +: DATA_WIDTH];
  assign data_1_out  = out_q[1*DATA_WIDTH +: DATA_WIDTH];
  assign data_2_out  = out_q[2*DATA_WIDTH +: DATA_WIDTH];
  assign data_3_out  = out_q[3*DATA_WIDTH +: DATA_WIDTH];
  assign valid_0_out = out_q[4*DATA_WIDTH + 0];
  assign valid_1_out = out_q[4*DATA_WIDTH + 1];
  assign valid_2_out = out_q[4*DATA_WIDTH + 2];
  assign valid_3_out = out_q[4*DATA_WIDTH + 3];
  assign pause       = pause_q;
  assign fifo_empty  = empty_s;
  assign fifo_full   = full_s;
  assign state       = state_q;
`ifdef RECIRC_MERGE_OVF_EN
  assign overflow_err = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_recirc_merge.sv
// Directed and random checks of recirc_merge against a queue-based reference model.
module tb_recirc_merge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fdat, rdat;
  logic [3:0]  fv, rv;
  wire  [31:0] odat;
  wire  [3:0]  ov;
  wire  [1:0]  st;
  wire         pause, fifo_empty, fifo_full;
`ifdef RECIRC_MERGE_OVF_EN
  wire         overflow_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [35:0] q[$];
  logic [35:0] exp_w;
  logic [1:0]  exp_st;
  bit          exp_ovf;

  always #5 clk = ~clk;

  recirc_merge dut (
    .clk(clk), .reset(reset),
    .data_0(fdat[7:0]), .data_1(fdat[15:8]), .data_2(fdat[23:16]), .data_3(fdat[31:24]),
    .valid_0(fv[0]), .valid_1(fv[1]), .valid_2(fv[2]), .valid_3(fv[3]),
    .data_0r(rdat[7:0]), .data_1r(rdat[15:8]), .data_2r(rdat[23:16]), .data_3r(rdat[31:24]),
    .valid_0r(rv[0]), .valid_1r(rv[1]), .valid_2r(rv[2]), .valid_3r(rv[3]),
    .data_0_out(odat[7:0]), .data_1_out(odat[15:8]), .data_2_out(odat[23:16]), .data_3_out(odat[31:24]),
    .valid_0_out(ov[0]), .valid_1_out(ov[1]), .valid_2_out(ov[2]), .valid_3_out(ov[3]),
    .pause(pause), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
`ifdef RECIRC_MERGE_OVF_EN
    .overflow_err(overflow_err),
`endif
    .state(st)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] f_v, input logic [31:0] f_d,
                        input logic [3:0] r_v, input logic [31:0] r_d);
    fv = f_v; fdat = f_d; rv = r_v; rdat = r_d;
  endtask

  // Reference: one merged word per cycle, fresh words queue behind older ones.
  task automatic model(input logic rst);
    logic [35:0] fw, rw;
    fw = {fv, fdat};
    rw = {rv, rdat};
    if (rst) begin
      q.delete(); exp_w = '0; exp_st = 2'd0; exp_ovf = 1'b0;
    end else if (rv != 4'd0) begin
      exp_w = rw; exp_st = 2'd1;
      if (fv != 4'd0) begin
        if (q.size() < 4) q.push_back(fw);
        else exp_ovf = 1'b1;
      end
    end else if (q.size() > 0) begin
      exp_w = q.pop_front(); exp_st = 2'd2;
      if (fv != 4'd0) q.push_back(fw);
    end else if (fv != 4'd0) begin
      exp_w = fw; exp_st = 2'd0;
    end else begin
      exp_w = '0; exp_st = 2'd0;
    end
  endtask

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    model(rst);
    #1;
    chk("data", {4'd0, odat}, {4'd0, exp_w[31:0]});
    chk("valid", {32'd0, ov}, {32'd0, exp_w[35:32]});
    chk("state", {34'd0, st}, {34'd0, exp_st});
    chk("pause", {35'd0, pause}, {35'd0, (q.size() >= 3)});
    chk("fifo_empty", {35'd0, fifo_empty}, {35'd0, (q.size() == 0)});
    chk("fifo_full", {35'd0, fifo_full}, {35'd0, (q.size() == 4)});
`ifdef RECIRC_MERGE_OVF_EN
    chk("overflow_err", {35'd0, overflow_err}, {35'd0, exp_ovf});
`endif
  endtask

  task automatic rand_in();
    set_in(4'($urandom), $urandom, 4'($urandom), $urandom);
  endtask

  initial begin
    // Reset held two cycles with random inputs
    rand_in(); step(1'b1);
    rand_in(); step(1'b1);

    // Bypass
    set_in(4'hF, 32'hA4A3A2A1, 4'h0, 32'h0); step(1'b0);
    set_in(4'h0, 32'h0, 4'h0, 32'h0); step(1'b0);

    // Priority then drain
    for (int k = 0; k < 3; k++) begin
      set_in(4'hF, {4{8'(8'h20 + k)}}, 4'hF, 32'h13121110);
      step(1'b0);
    end
    set_in(4'h0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) step(1'b0);

    // Fill past full with overflow
    for (int k = 0; k < 6; k++) begin
      set_in(4'hF, {4{8'(8'h40 + k)}}, 4'h5, 32'h00330011);
      step(1'b0);
    end

    // Full with push and pop every cycle
    for (int k = 0; k < 6; k++) begin
      set_in(4'($urandom_range(1, 15)), {4{8'(8'h60 + k)}}, 4'h0, 32'h0);
      step(1'b0);
    end
    set_in(4'h0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) step(1'b0);

    // Reset mid-drain discards buffered words
    step(1'b1);
    for (int k = 0; k < 2; k++) begin
      set_in(4'hF, {4{8'(8'h80 + k)}}, 4'hF, 32'h0);
      step(1'b0);
    end
    set_in(4'h0, 32'h0, 4'h0, 32'h0); step(1'b0);
    rand_in(); step(1'b1);
    set_in(4'h0, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b0);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom,
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), $urandom);
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
